// File: rtl/pla_pkg.sv
// Shared literal encoding and match helper for the programmable PLA engine.
package pla_pkg;

  typedef logic [1:0] lit_t;

  localparam lit_t LIT_VOID = 2'b00;
  localparam lit_t LIT_NEG  = 2'b01;
  localparam lit_t LIT_POS  = 2'b10;
  localparam lit_t LIT_DC   = 2'b11;

  // VOID can never be satisfied, so one VOID literal disables the whole row.
  function automatic logic lit_match(lit_t lit, logic x);
    case (lit)
      LIT_NEG:  return ~x;
      LIT_POS:  return x;
      LIT_DC:   return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pla_term_eval.sv
// One AND-plane row: fires when every literal in the row matches the input vector.
module pla_term_eval
  import pla_pkg::*;
#(
  parameter int N_IN = 27
) (
  input  logic [2*N_IN-1:0] and_row,
  input  logic [N_IN-1:0]   x,
  output logic              fire
);

  // NOTE: always_comb uses blocking '=' and assigns a default before the loop,
  // so no latch is inferred and the running AND sees its own update.
  always_comb begin
    fire = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      fire = fire & lit_match(lit_t'(and_row[2*i +: 2]), x[i]);
    end
  end

endmodule

// File: rtl/pla_prog_pipe.sv
// Run-time programmable PLA with a 2-stage valid/ready pipeline and drain-gated config writes.
// Optional macro PLA_OUT_POLARITY_EN adds a per-output inversion register (cfg_pol_we/cfg_pol).
module pla_prog_pipe
  import pla_pkg::*;
#(
  parameter int N_IN   = 27,
  parameter int N_TERM = 32,
  parameter int N_OUT  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN-1:0]           in_x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT-1:0]          out_z,
  output logic                      out_hit,
  input  logic                      cfg_we,
  input  logic [$clog2(N_TERM)-1:0] cfg_term,
  input  logic [2*N_IN-1:0]         cfg_and,
  input  logic [N_OUT-1:0]          cfg_or,
`ifdef PLA_OUT_POLARITY_EN
  input  logic                      cfg_pol_we,
  input  logic [N_OUT-1:0]          cfg_pol,
`endif
  output logic                      cfg_ack
);

  logic [2*N_IN-1:0] and_plane [N_TERM];
  logic [N_OUT-1:0]  or_plane  [N_TERM];
  logic [N_TERM-1:0] term_fire;
  logic [N_TERM-1:0] s1_terms;
  logic [N_OUT-1:0]  or_result;
  logic [N_OUT-1:0]  z_next;
  logic              s1_v, s2_v;
  logic              s1_adv, s2_adv;
  logic              accept, cfg_req;

`ifdef PLA_OUT_POLARITY_EN
  logic [N_OUT-1:0] pol;
  assign cfg_req = cfg_we | cfg_pol_we;
  assign z_next  = or_result ^ pol;
`else
  assign cfg_req = cfg_we;
  assign z_next  = or_result;
`endif

  // A pending config write blocks new inputs, so it only commits once the pipe is empty.
  assign s2_adv    = ~s2_v | out_ready;
  assign s1_adv    = ~s1_v | s2_adv;
  assign in_ready  = ~rst & s1_adv & ~cfg_req;
  assign accept    = in_valid & in_ready;
  assign cfg_ack   = ~rst & cfg_req & ~s1_v & ~s2_v;
  assign out_valid = s2_v;

  for (genvar t = 0; t < N_TERM; t++) begin : g_term
    pla_term_eval #(.N_IN(N_IN)) u_eval (
      .and_row (and_plane[t]),
      .x       (in_x),
      .fire    (term_fire[t])
    );
  end

  always_comb begin
    or_result = '0;
    for (int t = 0; t < N_TERM; t++) begin
      if (s1_terms[t]) or_result = or_result | or_plane[t];
    end
  end

  // NOTE: the planes are a register array cleared by reset on purpose: an
  // unprogrammed engine must evaluate to all-VOID, so this cannot map to RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < N_TERM; t++) begin
        and_plane[t] <= '0;
        or_plane[t]  <= '0;
      end
    end else if (cfg_ack && cfg_we && (int'(cfg_term) < N_TERM)) begin
      and_plane[cfg_term] <= cfg_and;
      or_plane[cfg_term]  <= cfg_or;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s1_terms <= '0;
      out_z    <= '0;
      out_hit  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_v <= accept;
        if (accept) s1_terms <= term_fire;
      end
      // Output registers only load on advance, holding z/hit stable under backpressure.
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_z   <= z_next;
          out_hit <= |s1_terms;
        end
      end
    end
  end

`ifdef PLA_OUT_POLARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pol <= '0;
    end else if (cfg_ack && cfg_pol_we) begin
      pol <= cfg_pol;
    end
  end
`endif

endmodule
